// File: rtl/instr_fetch.sv
// Instruction front end: assembles 16-bit instructions from a byte stream
// (low byte first), buffers them in a small FIFO and presents the head
// instruction to the control block over a valid/ready handshake.
module instr_fetch #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PTR_W:0]         count,
    output logic                   overflow
);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    phase_e                 phase_q,    phase_d;
    logic [DATA_WIDTH-1:0]  hold_q,     hold_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR_W:0]         count_q,    count_d;
    logic                   overflow_q, overflow_d;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic mem_we;

    // Outputs decoded from registered state only, so no input reaches an output.
    always_comb begin
        byte_ready  = (phase_q == PH_LOW) || (count_q != FULL);
        instr_valid = (count_q != '0);
        instr_out   = instr_valid ? mem[rd_ptr_q] : '0;
        count       = count_q;
        overflow    = overflow_q;
    end

    // Next-state logic: assembler phase, pointers, occupancy and sticky overflow.
    always_comb begin
        // NOTE: every _d signal is assigned its hold value first so no path
        // through this block can leave it unassigned and infer a latch.
        phase_d    = phase_q;
        hold_d     = hold_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        accept = byte_valid && byte_ready;
        push   = accept && (phase_q == PH_HIGH);
        pop    = instr_valid && instr_ready;
        mem_we = 1'b0;

        if (flush) begin
            // Pending low byte, push and pop of this cycle are all discarded.
            phase_d    = PH_LOW;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                if (phase_q == PH_LOW) begin
                    hold_d  = byte_in;
                    phase_d = PH_HIGH;
                end else begin
                    phase_d = PH_LOW;
                end
            end
            if (byte_valid && !byte_ready) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            mem_we  = push && !rst;
        end
    end

    // State registers with synchronous reset; reset overrides flush, push and pop.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            phase_q    <= PH_LOW;
            hold_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write port: a completed instruction lands at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are only visible
        // while count is non-zero, and leaving them unreset keeps this a plain RAM.
        if (mem_we) begin
            mem[wr_ptr_q] <= {byte_in, hold_q};
        end
    end

endmodule
